// File: rtl/alu_74382_serial_ctrl_if.sv
// Request/response handshake bundle for the serial 74382 controller.
// master = request source / response sink, slave = controller.
interface alu_74382_serial_ctrl_if #(
    parameter int WORD_W   = 16,
    parameter int SELECT_W = 3
);
    logic                req_valid;
    logic                req_ready;
    logic [SELECT_W-1:0] req_sel;
    logic                req_carry_in;
    logic [WORD_W-1:0]   req_a;
    logic [WORD_W-1:0]   req_b;
    logic                rsp_valid;
    logic                rsp_ready;
    logic [WORD_W-1:0]   rsp_result;
    logic                rsp_carry_out;
    logic                rsp_overflow;

    modport master (
        output req_valid, req_sel, req_carry_in, req_a, req_b, rsp_ready,
        input  req_ready, rsp_valid, rsp_result, rsp_carry_out, rsp_overflow
    );

    modport slave (
        input  req_valid, req_sel, req_carry_in, req_a, req_b, rsp_ready,
        output req_ready, rsp_valid, rsp_result, rsp_carry_out, rsp_overflow
    );
endinterface

// File: rtl/alu_74382_serial_ctrl.sv
// Runs a WORD_W-bit 74382 operation through one SLICE_W-bit ALU slice,
// LSB slice first, rippling the slice carry between cycles.
module alu_74382_serial_ctrl #(
    parameter  int WORD_W     = 16,
    parameter  int SLICE_W    = 4,
    localparam int SELECT_W   = 3,
    localparam int NUM_SLICES = WORD_W / SLICE_W
) (
    input  logic                clk,
    input  logic                rst_n,
    alu_74382_serial_ctrl_if.slave bus,
    output logic [SELECT_W-1:0] alu_sel,
    output logic                alu_carry_in,
    output logic [SLICE_W-1:0]  alu_port_a,
    output logic [SLICE_W-1:0]  alu_port_b,
    input  logic [SLICE_W-1:0]  alu_result,
    input  logic                alu_carry_out,
    input  logic                alu_overflow
);

    localparam int IDX_W = (NUM_SLICES > 1) ? $clog2(NUM_SLICES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_SLICES - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_e;

    state_e              state_q;
    logic [IDX_W-1:0]    idx_q;
    logic                carry_q;
    logic [SELECT_W-1:0] sel_q;
    logic [WORD_W-1:0]   a_q;
    logic [WORD_W-1:0]   b_q;
    logic [WORD_W-1:0]   result_q;
    logic                cout_q;
    logic                ovf_q;
    logic                run;

    assign run = (state_q == RUN);

    // Slice datapath is combinational from registered state only
    assign alu_sel      = run ? sel_q : '0;
    assign alu_carry_in = run ? carry_q : 1'b0;
    assign alu_port_a   = run ? a_q[int'(idx_q)*SLICE_W +: SLICE_W] : '0;
    assign alu_port_b   = run ? b_q[int'(idx_q)*SLICE_W +: SLICE_W] : '0;

    assign bus.req_ready     = (state_q == IDLE);
    assign bus.rsp_valid     = (state_q == DONE);
    assign bus.rsp_result    = result_q;
    assign bus.rsp_carry_out = cout_q;
    assign bus.rsp_overflow  = ovf_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            idx_q    <= '0;
            carry_q  <= 1'b0;
            sel_q    <= '0;
            a_q      <= '0;
            b_q      <= '0;
            result_q <= '0;
            cout_q   <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (bus.req_valid) begin
                        sel_q   <= bus.req_sel;
                        a_q     <= bus.req_a;
                        b_q     <= bus.req_b;
                        carry_q <= bus.req_carry_in;
                        idx_q   <= '0;
                        state_q <= RUN;
                    end
                end
                RUN: begin
                    result_q[int'(idx_q)*SLICE_W +: SLICE_W] <= alu_result;
                    carry_q <= alu_carry_out;
                    idx_q   <= idx_q + 1'b1;
                    if (idx_q == LAST_IDX) begin
                        cout_q  <= alu_carry_out;
                        ovf_q   <= alu_overflow;
                        idx_q   <= '0;
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    if (bus.rsp_ready) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_74382_serial_ctrl.sv
// Directed bench for the serial 74382 controller with a behavioural
// 4-bit 74382 slice attached to its ALU port.
module tb_alu_74382_serial_ctrl;

    logic       clk;
    logic       rst_n;
    logic [2:0] alu_sel;
    logic       alu_carry_in;
    logic [3:0] alu_port_a;
    logic [3:0] alu_port_b;
    logic [3:0] alu_result;
    logic       alu_carry_out;
    logic       alu_overflow;

    int checks;
    int errors;
    logic cins [4];

    alu_74382_serial_ctrl_if #(.WORD_W(16), .SELECT_W(3)) bus ();

    alu_74382_serial_ctrl #(.WORD_W(16), .SLICE_W(4)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .bus          (bus),
        .alu_sel      (alu_sel),
        .alu_carry_in (alu_carry_in),
        .alu_port_a   (alu_port_a),
        .alu_port_b   (alu_port_b),
        .alu_result   (alu_result),
        .alu_carry_out(alu_carry_out),
        .alu_overflow (alu_overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural 74382 slice
    logic [3:0] m_x;
    logic [3:0] m_y;
    logic [4:0] m_s;
    logic       m_arith;
    always_comb begin
        m_x     = 4'h0;
        m_y     = 4'h0;
        m_s     = 5'h00;
        m_arith = 1'b0;
        case (alu_sel)
            3'b001: begin m_x = alu_port_b; m_y = ~alu_port_a; m_arith = 1'b1; end
            3'b010: begin m_x = alu_port_a; m_y = ~alu_port_b; m_arith = 1'b1; end
            3'b011: begin m_x = alu_port_a; m_y = alu_port_b;  m_arith = 1'b1; end
            default: m_arith = 1'b0;
        endcase
        m_s = {1'b0, m_x} + {1'b0, m_y} + {4'h0, alu_carry_in};
        alu_result    = 4'h0;
        alu_carry_out = 1'b0;
        alu_overflow  = 1'b0;
        if (m_arith) begin
            alu_result    = m_s[3:0];
            alu_carry_out = m_s[4];
            alu_overflow  = (m_x[3] == m_y[3]) && (m_s[3] != m_x[3]);
        end else begin
            case (alu_sel)
                3'b100:  alu_result = alu_port_a ^ alu_port_b;
                3'b101:  alu_result = alu_port_a | alu_port_b;
                3'b110:  alu_result = alu_port_a & alu_port_b;
                3'b111:  alu_result = 4'hF;
                default: alu_result = 4'h0;
            endcase
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic start_op(input logic [2:0] sel, input logic [15:0] a,
                            input logic [15:0] b, input logic cin);
        @(negedge clk);
        chk("req_ready_idle", 32'(bus.req_ready), 32'd1);
        bus.req_valid    = 1'b1;
        bus.req_sel      = sel;
        bus.req_a        = a;
        bus.req_b        = b;
        bus.req_carry_in = cin;
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
    endtask

    task automatic run_slices(input logic [2:0] sel, input logic [15:0] a,
                              input logic [15:0] b);
        logic [15:0] av;
        logic [15:0] bv;
        av = a;
        bv = b;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("rsp_valid_busy", 32'(bus.rsp_valid), 32'd0);
            chk("req_ready_busy", 32'(bus.req_ready), 32'd0);
            chk("alu_sel", 32'(alu_sel), 32'(sel));
            chk("alu_port_a", 32'(alu_port_a), 32'(av[k*4 +: 4]));
            chk("alu_port_b", 32'(alu_port_b), 32'(bv[k*4 +: 4]));
            cins[k] = alu_carry_in;
            @(posedge clk);
        end
    endtask

    task automatic check_rsp(input string tag, input logic [15:0] res,
                             input logic co, input logic ov);
        @(negedge clk);
        chk({tag, "_valid"}, 32'(bus.rsp_valid), 32'd1);
        chk({tag, "_result"}, 32'(bus.rsp_result), 32'(res));
        chk({tag, "_cout"}, 32'(bus.rsp_carry_out), 32'(co));
        chk({tag, "_ovf"}, 32'(bus.rsp_overflow), 32'(ov));
        chk({tag, "_alu_idle"}, 32'({alu_sel, alu_port_a, alu_port_b}), 32'd0);
    endtask

    task automatic ack();
        bus.rsp_ready = 1'b1;
        @(posedge clk);
        #1 bus.rsp_ready = 1'b0;
        @(negedge clk);
        chk("ack_req_ready", 32'(bus.req_ready), 32'd1);
        chk("ack_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    endtask

    initial begin
        checks           = 0;
        errors           = 0;
        rst_n            = 1'b0;
        bus.req_valid    = 1'b0;
        bus.req_sel      = 3'b000;
        bus.req_a        = 16'h0000;
        bus.req_b        = 16'h0000;
        bus.req_carry_in = 1'b0;
        bus.rsp_ready    = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_req_ready", 32'(bus.req_ready), 32'd1);
        chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("rst_result", 32'(bus.rsp_result), 32'd0);
        chk("rst_flags", 32'({bus.rsp_carry_out, bus.rsp_overflow}), 32'd0);
        chk("rst_alu", 32'({alu_sel, alu_carry_in, alu_port_a, alu_port_b}), 32'd0);
        rst_n = 1'b1;

        // ADD with carry ripple across slice boundary
        start_op(3'b011, 16'h00FF, 16'h0001, 1'b0);
        run_slices(3'b011, 16'h00FF, 16'h0001);
        check_rsp("add1", 16'h0100, 1'b0, 1'b0);
        ack();

        // ADD signed overflow in MSB slice
        start_op(3'b011, 16'h4000, 16'h4000, 1'b0);
        run_slices(3'b011, 16'h4000, 16'h4000);
        check_rsp("add_ovf", 16'h8000, 1'b0, 1'b1);
        ack();

        // A minus B, carry chain stays 1 (no borrow)
        start_op(3'b010, 16'h1234, 16'h0234, 1'b1);
        run_slices(3'b010, 16'h1234, 16'h0234);
        check_rsp("sub", 16'h1000, 1'b1, 1'b0);
        chk("sub_cins", 32'({cins[3], cins[2], cins[1], cins[0]}), 32'hF);
        ack();

        start_op(3'b100, 16'hA5A5, 16'hFFFF, 1'b0);
        run_slices(3'b100, 16'hA5A5, 16'hFFFF);
        check_rsp("xor", 16'h5A5A, 1'b0, 1'b0);
        ack();

        start_op(3'b111, 16'h1357, 16'h2468, 1'b0);
        run_slices(3'b111, 16'h1357, 16'h2468);
        check_rsp("preset", 16'hFFFF, 1'b0, 1'b0);
        ack();

        // Backpressure with a competing request held
        start_op(3'b011, 16'h0F0F, 16'h0101, 1'b1);
        run_slices(3'b011, 16'h0F0F, 16'h0101);
        check_rsp("bp", 16'h1011, 1'b0, 1'b0);
        bus.req_valid = 1'b1;
        bus.req_sel   = 3'b111;
        bus.req_a     = 16'hDEAD;
        bus.req_b     = 16'hBEEF;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_valid", 32'(bus.rsp_valid), 32'd1);
            chk("bp_req_ready", 32'(bus.req_ready), 32'd0);
            chk("bp_result", 32'(bus.rsp_result), 32'h1011);
        end
        bus.req_valid = 1'b0;
        ack();
        @(negedge clk);
        chk("bp_no_start", 32'({bus.req_ready, alu_sel}), 32'({1'b1, 3'b000}));

        // Reset while slice 2 is presented
        start_op(3'b011, 16'hFFFF, 16'h0001, 1'b0);
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            @(posedge clk);
        end
        @(negedge clk);
        chk("mid_slice2_a", 32'(alu_port_a), 32'hF);
        rst_n = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("mid_req_ready", 32'(bus.req_ready), 32'd1);
        chk("mid_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("mid_result", 32'(bus.rsp_result), 32'd0);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("mid_no_rsp", 32'({bus.rsp_valid, bus.req_ready}), 32'b01);
        end

        start_op(3'b011, 16'h0001, 16'h0001, 1'b0);
        run_slices(3'b011, 16'h0001, 16'h0001);
        check_rsp("post_rst", 16'h0002, 1'b0, 1'b0);
        ack();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_74382_serial_ctrl.md
# alu_74382_serial_ctrl

Sequencing controller that executes a WORD_W-bit 74382 operation by driving a single SLICE_W-bit alu_74382 instance one slice per cycle, LSB slice first, chaining slice carry_out into the next slice's carry_in. It sits between a valid/ready request source and the combinational ALU slice. Results are bit-identical to NUM_SLICES cascaded 74382 devices. Word results return on a valid/ready response channel.

## Interface
- WORD_W, 16, operand/result width; must be an integer multiple of SLICE_W
- SLICE_W, ORIG_OPERAND_W (4), width of the attached ALU slice
- NUM_SLICES, WORD_W/SLICE_W (derived localparam, not overridable)

Ports (clock and reset first):
- clk  in  1  single clock, all state updates on rising edge
- rst_n  in  1  reset, synchronous, active-low
- req_valid  in  1  request present
- req_ready  out  1  controller can accept a request; high only in IDLE
- req_sel  in  SELECT_W  74382 op code (alu_74382_pkg encoding)
- req_carry_in  in  1  carry into LSB slice (1 = no borrow for subtracts)
- req_a / req_b  in  WORD_W  operands
- rsp_valid  out  1  response present
- rsp_ready  in  1  response consumer ready
- rsp_result  out  WORD_W  word result
- rsp_carry_out  out  1  carry_out of MSB slice
- rsp_overflow  out  1  overflow of MSB slice
- alu_sel  out  SELECT_W  to ALU slice
- alu_carry_in  out  1  to ALU slice
- alu_port_a / alu_port_b  out  SLICE_W  current operand slices
- alu_result  in  SLICE_W  from ALU slice
- alu_carry_out / alu_overflow  in  1  from ALU slice

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE: req_ready=1. On req_valid: latch req_sel, req_a, req_b; carry_reg <= req_carry_in; slice_idx <= 0; -> RUN.
- RUN: alu_sel = latched sel; alu_port_a/b = operand bits [slice_idx*SLICE_W +: SLICE_W]; alu_carry_in = carry_reg. Each edge: write alu_result into rsp_result at the same slice position; carry_reg <= alu_carry_out; slice_idx++. On slice_idx == NUM_SLICES-1: rsp_carry_out <= alu_carry_out; rsp_overflow <= alu_overflow; -> DONE.
- DONE: rsp_valid=1; rsp_result/carry/overflow held stable. On rsp_ready -> IDLE.
- Outside RUN: alu_sel = 0, alu_port_a/b = 0, alu_carry_in = 0.
- Carry is chained for every op code, logic ops included; no per-op special casing in the controller.
- Requests are never accepted in RUN or DONE; one operation in flight.
- rst_n low at any edge: state <= IDLE, slice_idx <= 0, carry_reg <= 0, rsp_result <= 0, rsp_carry_out <= 0, rsp_overflow <= 0. An operation in progress is discarded; no response is produced.

## Timing
- Reset values: req_ready=1 (IDLE), rsp_valid=0, rsp_result=0, rsp_carry_out=0, rsp_overflow=0, alu_* = 0.
- Acceptance edge E0 (req_valid & req_ready). Slice k is presented to the ALU in the cycle after edge Ek and captured at edge E(k+1).
- rsp_valid rises after edge E(NUM_SLICES): NUM_SLICES cycles after acceptance (4 for defaults).
- On the response handshake edge, the FSM enters IDLE; req_ready is high in the following cycle. Minimum issue interval is NUM_SLICES+2 cycles.
- req_ready and rsp_valid are decoded from registered state only; no combinational path from req_valid or rsp_ready to them.
- The ALU path is combinational within one cycle: alu_* out -> alu_* in -> capture registers.

## Test plan
- ADD (sel 011), a=0x00FF, b=0x0001, cin=0 -> rsp_result=0x0100, carry_out=0, overflow=0; rsp_valid exactly 4 cycles after acceptance.
- ADD, a=0x4000, b=0x4000, cin=0 -> rsp_result=0x8000, carry_out=0, overflow=1.
- A_SUB_B (sel 010), a=0x1234, b=0x0234, cin=1 -> rsp_result=0x1000, carry_out=1, overflow=0; alu_carry_in seen as 1,1,1,1 across the four slices.
- XOR (sel 100), a=0xA5A5, b=0xFFFF, cin=0 -> rsp_result=0x5A5A, carry_out=0, overflow=0. PRESET (sel 111) with any operands -> rsp_result=0xFFFF.
- Backpressure: hold rsp_ready=0 for 5 cycles after rsp_valid -> rsp_* stable, req_ready=0, a new req_valid is ignored. Release -> one handshake, req_ready=1 in the next cycle.
- Reset mid-op: drive rst_n=0 for one edge while slice 2 is presented -> next cycle req_ready=1, rsp_valid=0, rsp_result=0. No response appears. A fresh ADD 0x0001+0x0001 then returns 0x0002.
